rpi_serial_rx: RTL

- Receives audio sample words that the Raspberry Pi clocks into the FPGA.
- Requests data from the Pi with interrupt_enable, which feeds the interrupt-clock generator's enable input.
- Captures MSB-first serial frames on a Pi-driven clock, then buffers completed words in a small first-word-fall-through (FWFT) FIFO for the audio codec path.
- All logic runs in the 50 MHz clk_in domain; Pi signals are asynchronous.

---
 rtl/rpi_serial_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rpi_serial_rx.sv
// Serial word receiver for Pi-driven audio samples: synchronizes the Pi lines,
// deserializes MSB-first frames, and buffers words in a small FWFT FIFO.
module rpi_serial_rx #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int LOW_WATER = 2
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     rpi_sclk,
  input  logic                     rpi_data,
  input  logic                     rpi_cs_n,
  output logic                     interrupt_enable,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     frame_error
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] LW_CNT   = CNTW'(LOW_WATER);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Synchronizers: [1] is the synchronized level, [2] the previous level.
  logic [2:0] sclk_sr, cs_sr;
  logic [1:0] data_sr;
  logic       sclk_rise, cs_fall, cs_rise;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sclk_sr <= '0;
      cs_sr   <= '0;
      data_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], rpi_sclk};
      cs_sr   <= {cs_sr[1:0], rpi_cs_n};
      data_sr <= {data_sr[0], rpi_data};
    end
  end

  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign cs_fall   = ~cs_sr[1] & cs_sr[2];
  assign cs_rise   = cs_sr[1] & ~cs_sr[2];

  state_t            state, state_n;
  logic [CW-1:0]     bit_cnt;
  logic [WIDTH-1:0]  shreg;
  logic              shift_en, clr_cnt, word_done, err_n;
  logic              push, run;

  always_comb begin
    state_n   = state;
    shift_en  = 1'b0;
    clr_cnt   = 1'b0;
    word_done = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: if (cs_fall) begin
        state_n = SHIFT;
        clr_cnt = 1'b1;
      end
      // cs_n rising takes priority over a coincident sclk edge.
      SHIFT: if (cs_rise) begin
        state_n = IDLE;
        err_n   = (bit_cnt != '0);
      end else if (sclk_rise) begin
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_n   = DONE;
          word_done = 1'b1;
        end
      end
      DONE: if (cs_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // run holds off interrupt_enable for one cycle after reset release.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shreg            <= '0;
      push             <= 1'b0;
      frame_error      <= 1'b0;
      run              <= 1'b0;
      interrupt_enable <= 1'b0;
    end else begin
      state       <= state_n;
      push        <= word_done;
      frame_error <= err_n;
      run         <= 1'b1;
      interrupt_enable <= run && (state == IDLE) && (fifo_count < LW_CNT);
      if (clr_cnt) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + CW'(1);
      if (shift_en) shreg <= {shreg[WIDTH-2:0], data_sr[1]};
    end
  end

  // FWFT FIFO; the head word is read combinationally from storage.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, pop, wr;

  assign full  = (fifo_count == FULL_CNT);
  assign empty = (fifo_count == '0);
  assign pop   = rd_en & ~empty;
  assign wr    = push & (~full | pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
